plic_claim_sequencer: RTL and testbench
=======================================

PLIC_CLAIM_SEQUENCER -- requirements
Module: plic_claim_sequencer

Interface
REQ-001 SHALL have parameter N_SOURCE, default 30, number of PLIC interrupt sources.
REQ-002 SHALL have parameter SRCW, default $clog2(N_SOURCE+1), width of an interrupt ID.
REQ-003 SHALL have parameter CC_ADDR, default 32'h0020_0004, claim/complete register address of the served target.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles for reg_ready_i (range 1..255).
REQ-005 SHALL have port clk_i, input, 1, clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port eip_i, input, 1, external interrupt pending from the PLIC target.
REQ-008 SHALL have port reg_valid_o, output, 1, register bus request valid.
REQ-009 SHALL have port reg_write_o, output, 1, 1 = write, 0 = read.
REQ-010 SHALL have port reg_addr_o, output, 32, request address.
REQ-011 SHALL have port reg_wdata_o, output, 32, write data.
REQ-012 SHALL have port reg_wstrb_o, output, 4, write byte strobes.
REQ-013 SHALL have port reg_rdata_i, input, 32, read data.
REQ-014 SHALL have port reg_ready_i, input, 1, request accepted/completed this cycle.
REQ-015 SHALL have port reg_error_i, input, 1, bus error, qualified by reg_ready_i.
REQ-016 SHALL have ports irq_valid_o (output, 1), irq_id_o (output, SRCW), irq_ready_i (input, 1): handler dispatch handshake.
REQ-017 SHALL have port done_i, input, 1, handler finished servicing the dispatched ID.
REQ-018 SHALL have ports busy_o (output, 1, state != IDLE), err_o (output, 1, sticky error), clear_err_i (input, 1).
REQ-019 SHALL have port spurious_cnt_o, output, 8, saturating count of zero-ID claims.

Function
REQ-020 SHALL implement states IDLE, CLAIM, DISPATCH, SERVICE, COMPLETE, HOLDOFF; all outputs SHALL be registered.
REQ-021 IDLE: eip_i=1 -> CLAIM; reg_valid_o=1, reg_write_o=0, reg_addr_o=CC_ADDR from the next cycle.
REQ-022 While reg_valid_o=1, reg_write_o/reg_addr_o/reg_wdata_o/reg_wstrb_o SHALL stay stable until the cycle reg_ready_i=1; reg_valid_o SHALL drop the following cycle.
REQ-023 CLAIM, ready with error=0: id = reg_rdata_i[SRCW-1:0]; id=0 -> spurious_cnt_o +1 (saturate at 255), go HOLDOFF; 1..N_SOURCE -> latch irq_id_o, go DISPATCH; id>N_SOURCE or reg_rdata_i[31:SRCW]!=0 -> set err_o, go HOLDOFF.
REQ-024 DISPATCH: irq_valid_o=1, irq_id_o stable until irq_ready_i=1; then irq_valid_o=0 and go SERVICE.
REQ-025 SERVICE: done_i=1 -> COMPLETE; done_i SHALL be ignored in all other states.
REQ-026 COMPLETE: reg_valid_o=1, reg_write_o=1, reg_addr_o=CC_ADDR, reg_wdata_o=zero-extended irq_id_o, reg_wstrb_o=4'hF; on ready -> HOLDOFF.
REQ-027 HOLDOFF SHALL last exactly one cycle, then IDLE (masks stale eip_i from the registered PLIC target).
REQ-028 reg_ready_i with reg_error_i=1 in CLAIM or COMPLETE SHALL set err_o and go HOLDOFF without dispatch/complete.
REQ-029 An 8-bit wait counter SHALL clear on entering CLAIM/COMPLETE, increment each cycle reg_ready_i=0; reaching TIMEOUT SHALL drop reg_valid_o, set err_o, go HOLDOFF.
REQ-030 eip_i changes outside IDLE SHALL be ignored; irq_ready_i outside DISPATCH SHALL be ignored.
REQ-031 err_o SHALL clear on clear_err_i=1 unless a new error is set the same cycle (set wins).
REQ-032 Latency: eip_i rise in IDLE to reg_valid_o = 1 cycle; claim ready to irq_valid_o = 1 cycle; done_i to complete reg_valid_o = 1 cycle.

Reset
REQ-033 rst_ni=0 SHALL asynchronously force IDLE, all reg_* and irq_* outputs 0, busy_o=0, err_o=0, spurious_cnt_o=0, wait counter 0.
REQ-034 Reset mid-transaction SHALL abandon it; no complete write SHALL be issued for the abandoned ID after reset release.

Verification
REQ-035 eip_i=1, claim rdata=5, ready after 2 cycles; irq_ready_i immediate; done_i 3 cycles later -> one read, irq_id_o=5, one write wdata=5, back in IDLE after HOLDOFF.
REQ-036 Claim rdata=0 -> no irq_valid_o, no write, spurious_cnt_o=1; 256 such claims -> spurious_cnt_o=255.
REQ-037 Claim rdata=31 with N_SOURCE=30 -> err_o=1, no dispatch, no write; clear_err_i -> err_o=0.
REQ-038 reg_ready_i held 0 for TIMEOUT=255 cycles in CLAIM -> reg_valid_o drops, err_o=1, IDLE two cycles later.
REQ-039 irq_ready_i held 0 for 10 cycles with done_i pulsed -> irq_valid_o and irq_id_o stable, done_i ignored, SERVICE entered only after irq_ready_i.
REQ-040 rst_ni asserted during COMPLETE with reg_ready_i=0 -> all outputs 0 immediately, no write after release.

Source files
------------

// File: rtl/plic_claim_sequencer_if.sv
// Register-bus and handshake bundle between the claim sequencer and its environment.
// Signal suffixes are relative to the sequencer: master = sequencer, slave = bus/handler side.
interface plic_claim_sequencer_if #(
  parameter int unsigned SRCW = 5
);
  logic            reg_valid_o;
  logic            reg_write_o;
  logic [31:0]     reg_addr_o;
  logic [31:0]     reg_wdata_o;
  logic [3:0]      reg_wstrb_o;
  logic [31:0]     reg_rdata_i;
  logic            reg_ready_i;
  logic            reg_error_i;
  logic            irq_valid_o;
  logic [SRCW-1:0] irq_id_o;
  logic            irq_ready_i;
  logic            done_i;

  modport master (
    output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
    input  reg_rdata_i, reg_ready_i, reg_error_i,
    output irq_valid_o, irq_id_o,
    input  irq_ready_i, done_i
  );

  modport slave (
    input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
    output reg_rdata_i, reg_ready_i, reg_error_i,
    input  irq_valid_o, irq_id_o,
    output irq_ready_i, done_i
  );
endinterface

// File: rtl/plic_claim_sequencer.sv
// PLIC claim/complete sequencer: claims an interrupt ID over the register bus, dispatches it
// to a handler, waits for completion, writes the ID back, then holds off one cycle.
module plic_claim_sequencer #(
  parameter int unsigned N_SOURCE = 30,
  parameter int unsigned SRCW     = $clog2(N_SOURCE + 1),
  parameter logic [31:0] CC_ADDR  = 32'h0020_0004,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          eip_i,
  plic_claim_sequencer_if.master        bus,
  output logic                          busy_o,
  output logic                          err_o,
  input  logic                          clear_err_i,
  output logic [7:0]                    spurious_cnt_o
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StClaim,
    StDispatch,
    StService,
    StComplete,
    StHoldoff
  } state_e;

  state_e          state_q;
  logic            reg_valid_q;
  logic            reg_write_q;
  logic [31:0]     reg_addr_q;
  logic [31:0]     reg_wdata_q;
  logic [3:0]      reg_wstrb_q;
  logic            irq_valid_q;
  logic [SRCW-1:0] irq_id_q;
  logic            busy_q;
  logic            err_q;
  logic [7:0]      spur_q;
  logic [7:0]      wait_q;

  logic            claim_zero;
  logic            claim_ok;
  logic [7:0]      wait_inc;
  logic            wait_expired;

  // Claim data classification and wait-counter lookahead.
  always_comb begin
    claim_zero   = (bus.reg_rdata_i == 32'd0);
    // Any non-zero upper bit makes the value exceed N_SOURCE, so one compare covers both checks.
    claim_ok     = !claim_zero && (bus.reg_rdata_i <= 32'(N_SOURCE));
    wait_inc     = wait_q + 8'd1;
    wait_expired = (wait_inc == TimeoutCnt);
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      reg_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      spur_q      <= '0;
      wait_q      <= '0;
    end else begin
      // A later error set in the case below overrides this clear.
      if (clear_err_i) err_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (eip_i) begin
            state_q     <= StClaim;
            busy_q      <= 1'b1;
            reg_valid_q <= 1'b1;
            reg_write_q <= 1'b0;
            reg_addr_q  <= CC_ADDR;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
            wait_q      <= '0;
          end
        end

        StClaim: begin
          if (bus.reg_ready_i) begin
            reg_valid_q <= 1'b0;
            state_q     <= StHoldoff;
            if (bus.reg_error_i) begin
              err_q <= 1'b1;
            end else if (claim_zero) begin
              if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
            end else if (claim_ok) begin
              irq_id_q    <= bus.reg_rdata_i[SRCW-1:0];
              irq_valid_q <= 1'b1;
              state_q     <= StDispatch;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_inc;
            if (wait_expired) begin
              reg_valid_q <= 1'b0;
              err_q       <= 1'b1;
              state_q     <= StHoldoff;
            end
          end
        end

        StDispatch: begin
          if (bus.irq_ready_i) begin
            irq_valid_q <= 1'b0;
            state_q     <= StService;
          end
        end

        StService: begin
          if (bus.done_i) begin
            state_q     <= StComplete;
            reg_valid_q <= 1'b1;
            reg_write_q <= 1'b1;
            reg_addr_q  <= CC_ADDR;
            reg_wdata_q <= 32'(irq_id_q);
            reg_wstrb_q <= 4'hF;
            wait_q      <= '0;
          end
        end

        StComplete: begin
          if (bus.reg_ready_i) begin
            reg_valid_q <= 1'b0;
            state_q     <= StHoldoff;
            if (bus.reg_error_i) err_q <= 1'b1;
          end else begin
            wait_q <= wait_inc;
            if (wait_expired) begin
              reg_valid_q <= 1'b0;
              err_q       <= 1'b1;
              state_q     <= StHoldoff;
            end
          end
        end

        // One dead cycle lets the registered PLIC target drop eip before we sample it again.
        StHoldoff: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_valid_o = reg_valid_q;
  assign bus.reg_write_o = reg_write_q;
  assign bus.reg_addr_o  = reg_addr_q;
  assign bus.reg_wdata_o = reg_wdata_q;
  assign bus.reg_wstrb_o = reg_wstrb_q;
  assign bus.irq_valid_o = irq_valid_q;
  assign bus.irq_id_o    = irq_id_q;
  assign busy_o          = busy_q;
  assign err_o           = err_q;
  assign spurious_cnt_o  = spur_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Scoreboard bench for plic_claim_sequencer: the driver pushes expected bus/dispatch events from
// a transaction-level model, a negedge monitor pops and compares on every handshake.
module tb_plic_claim_sequencer;

  localparam int unsigned NSrc    = 30;
  localparam int unsigned SrcW    = 5;
  localparam logic [31:0] CcAddr  = 32'h0020_0004;
  localparam int unsigned TimeOut = 255;

  localparam int KRead  = 0;
  localparam int KWrite = 1;
  localparam int KDisp  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  err_m  = 1'b0;
  int  spur_m = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       eip;
  logic       clear_err;
  logic       busy;
  logic       err;
  logic [7:0] spur;

  plic_claim_sequencer_if #(.SRCW(SrcW)) bus_if ();

  plic_claim_sequencer #(
    .N_SOURCE (NSrc),
    .SRCW     (SrcW),
    .CC_ADDR  (CcAddr),
    .TIMEOUT  (TimeOut)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .eip_i          (eip),
    .bus            (bus_if),
    .busy_o         (busy),
    .err_o          (err),
    .clear_err_i    (clear_err),
    .spurious_cnt_o (spur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return bus_if.reg_valid_o;
      1:       return bus_if.irq_valid_o;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the number of rising edges waited; n==0 means already asserted.
  task automatic wait_for(input int sel, input int limit, output int n);
    n = 0;
    while (!probe(sel) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Monitor: compares every accepted handshake against the scoreboard, checks request stability.
  initial begin
    bit          prev_rv, prev_rr, prev_iv, prev_ir;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;
    logic        prev_write;
    logic [4:0]  prev_id;
    ev_t         e;
    prev_rv = 0; prev_rr = 0; prev_iv = 0; prev_ir = 0;
    prev_addr = '0; prev_wdata = '0; prev_wstrb = '0; prev_write = 1'b0; prev_id = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_rv = 0; prev_iv = 0;
      end else begin
        if (prev_rv && !prev_rr && bus_if.reg_valid_o) begin
          check("reg_hold_write", 32'(bus_if.reg_write_o), 32'(prev_write));
          check("reg_hold_addr", bus_if.reg_addr_o, prev_addr);
          check("reg_hold_wdata", bus_if.reg_wdata_o, prev_wdata);
          check("reg_hold_wstrb", 32'(bus_if.reg_wstrb_o), 32'(prev_wstrb));
        end
        if (prev_iv && !prev_ir && bus_if.irq_valid_o)
          check("irq_hold_id", 32'(bus_if.irq_id_o), 32'(prev_id));
        if (bus_if.reg_valid_o && bus_if.reg_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_reg_txn", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("reg_txn_kind", bus_if.reg_write_o ? 32'(KWrite) : 32'(KRead), 32'(e.kind));
            check("reg_txn_addr", bus_if.reg_addr_o, CcAddr);
            if (e.kind == KWrite) begin
              check("complete_wdata", bus_if.reg_wdata_o, e.data);
              check("complete_wstrb", 32'(bus_if.reg_wstrb_o), 32'hF);
            end
          end
        end
        if (bus_if.irq_valid_o && bus_if.irq_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_dispatch", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("dispatch_kind", 32'(KDisp), 32'(e.kind));
            check("dispatch_id", 32'(bus_if.irq_id_o), e.data);
          end
        end
        prev_rv    = bus_if.reg_valid_o;
        prev_rr    = bus_if.reg_ready_i;
        prev_iv    = bus_if.irq_valid_o;
        prev_ir    = bus_if.irq_ready_i;
        prev_addr  = bus_if.reg_addr_o;
        prev_wdata = bus_if.reg_wdata_o;
        prev_wstrb = bus_if.reg_wstrb_o;
        prev_write = bus_if.reg_write_o;
        prev_id    = bus_if.irq_id_o;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_reg_valid"}, 32'(bus_if.reg_valid_o), 32'd0);
    check({tag, "_reg_write"}, 32'(bus_if.reg_write_o), 32'd0);
    check({tag, "_reg_addr"}, bus_if.reg_addr_o, 32'd0);
    check({tag, "_reg_wdata"}, bus_if.reg_wdata_o, 32'd0);
    check({tag, "_reg_wstrb"}, 32'(bus_if.reg_wstrb_o), 32'd0);
    check({tag, "_irq_valid"}, 32'(bus_if.irq_valid_o), 32'd0);
    check({tag, "_irq_id"}, 32'(bus_if.irq_id_o), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_spur"}, 32'(spur), 32'd0);
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    err_m = 1'b0;
    check("clear_err", 32'(err), 32'd0);
  endtask

  // One interrupt transaction. Expected events come from the claim rules, not from the DUT.
  task automatic run_txn(input logic [31:0] rdata, input bit claim_err, input int claim_lat,
                         input int disp_lat, input int done_lat, input bit cmpl_err,
                         input int cmpl_lat, input bit clr_at_claim, input bit noise,
                         input bit rst_in_cmpl);
    int         n;
    bit         bad, disp;
    logic [4:0] id;
    id   = rdata[4:0];
    bad  = claim_err;
    disp = 1'b0;
    exp_q.push_back('{kind: KRead, data: CcAddr});
    if (!claim_err) begin
      if ((rdata >> SrcW) != 0 || 32'(id) > NSrc) bad = 1'b1;
      else if (id == 0) begin
        if (spur_m < 255) spur_m++;
      end else disp = 1'b1;
    end
    if (bad) err_m = 1'b1;
    else if (clr_at_claim) err_m = 1'b0;
    if (disp) begin
      exp_q.push_back('{kind: KDisp, data: 32'(id)});
      if (!rst_in_cmpl) begin
        exp_q.push_back('{kind: KWrite, data: 32'(id)});
        if (cmpl_err) err_m = 1'b1;
      end
    end

    eip = 1'b1;
    wait_for(0, 4, n);
    check("eip_to_claim_latency", 32'(n), 32'd1);
    eip = 1'b0;
    for (int i = 0; i < claim_lat; i++) begin
      if (noise) begin
        eip                = 1'($urandom_range(0, 1));
        bus_if.done_i      = 1'($urandom_range(0, 1));
        bus_if.irq_ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    eip = 1'b0; bus_if.done_i = 1'b0; bus_if.irq_ready_i = 1'b0;
    bus_if.reg_ready_i = 1'b1;
    bus_if.reg_rdata_i = rdata;
    bus_if.reg_error_i = claim_err;
    clear_err          = clr_at_claim;
    @(posedge clk); #1;
    bus_if.reg_ready_i = 1'b0;
    bus_if.reg_error_i = 1'b0;
    bus_if.reg_rdata_i = $urandom;
    clear_err          = 1'b0;

    if (disp) begin
      wait_for(1, 4, n);
      check("claim_to_dispatch_latency", 32'(n), 32'd0);
      for (int i = 0; i < disp_lat; i++) begin
        bus_if.done_i = noise && (i % 2 == 0);
        @(posedge clk); #1;
      end
      bus_if.done_i      = 1'b0;
      bus_if.irq_ready_i = 1'b1;
      @(posedge clk); #1;
      bus_if.irq_ready_i = 1'b0;
      check("irq_valid_drop", 32'(bus_if.irq_valid_o), 32'd0);
      for (int i = 0; i < done_lat; i++) begin
        check("no_write_before_done", 32'(bus_if.reg_valid_o), 32'd0);
        if (noise) eip = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      eip           = 1'b0;
      bus_if.done_i = 1'b1;
      @(posedge clk); #1;
      bus_if.done_i = 1'b0;
      wait_for(0, 4, n);
      check("done_to_complete_latency", 32'(n), 32'd0);

      if (rst_in_cmpl) begin
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_complete");
        err_m  = 1'b0;
        spur_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          check("no_write_after_reset", 32'(bus_if.reg_valid_o), 32'd0);
        end
        check("busy_after_reset", 32'(busy), 32'd0);
        return;
      end

      for (int i = 0; i < cmpl_lat; i++) begin @(posedge clk); #1; end
      bus_if.reg_ready_i = 1'b1;
      bus_if.reg_error_i = cmpl_err;
      @(posedge clk); #1;
      bus_if.reg_ready_i = 1'b0;
      bus_if.reg_error_i = 1'b0;
    end

    // Now in the holdoff cycle: a stale eip here must be ignored.
    check("holdoff_busy", 32'(busy), 32'd1);
    check("holdoff_no_dispatch", 32'(bus_if.irq_valid_o), 32'd0);
    eip = noise;
    @(posedge clk); #1;
    eip = 1'b0;
    check("idle_after_holdoff", 32'(busy), 32'd0);
    check("idle_reg_valid", 32'(bus_if.reg_valid_o), 32'd0);
    check("err_flag", 32'(err), 32'(err_m));
    check("spurious_cnt", 32'(spur), 32'(spur_m));
  endtask

  task automatic run_timeout();
    int n;
    eip = 1'b1;
    wait_for(0, 4, n);
    check("timeout_eip_latency", 32'(n), 32'd1);
    eip = 1'b0;
    n = 0;
    while (bus_if.reg_valid_o && n < 600) begin
      n++;
      @(posedge clk); #1;
    end
    check("timeout_valid_cycles", 32'(n), 32'(TimeOut));
    err_m = 1'b1;
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_holdoff_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("timeout_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          r;
    rst_n = 1'b1; eip = 1'b0; clear_err = 1'b0;
    bus_if.reg_rdata_i = '0; bus_if.reg_ready_i = 1'b0; bus_if.reg_error_i = 1'b0;
    bus_if.irq_ready_i = 1'b0; bus_if.done_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic claim of ID 5: ready after 2 cycles, immediate irq_ready, done 3 cycles later.
    run_txn(32'd5, 0, 2, 0, 3, 0, 1, 0, 0, 0);
    // Out-of-range ID 31 raises err without dispatch, then clear it.
    run_txn(32'd31, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    do_clear();
    // Bad claim with clear_err in the same cycle: set wins.
    run_txn(32'h0000_0105, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_clear();
    // Slow irq_ready with done pulses during dispatch.
    run_txn(32'd7, 0, 0, 10, 2, 0, 0, 0, 1, 0);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      rd = 32'($urandom_range(1, NSrc));
      else if (r < 75) rd = 32'd0;
      else if (r < 88) rd = 32'($urandom_range(NSrc + 1, (1 << SrcW) - 1));
      else             rd = (32'd1 << $urandom_range(SrcW, 31)) | 32'($urandom_range(0, NSrc));
      run_txn(rd, ($urandom_range(0, 9) == 0), $urandom_range(0, 4), $urandom_range(0, 5),
              $urandom_range(0, 5), ($urandom_range(0, 9) == 0), $urandom_range(0, 4),
              ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) do_clear();
    end

    do_clear();
    run_timeout();
    do_clear();

    // Spurious counter saturates at 255.
    for (int t = 0; t < 260; t++) run_txn(32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while the complete write is pending.
    run_txn(32'd9, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    // Recovery after reset.
    run_txn(32'd12, 0, 1, 1, 1, 0, 1, 0, 0, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
